// File: rtl/score_keeper_if.sv
// Score/combo/sound bus between the judge side and the score keeper.
//   i_Start        1-cycle pulse: clear everything and enter PLAY
//   i_Stop         1-cycle pulse: end of song, enter DONE
//   i_Judge_Valid  judgment strobe, one cycle per note
//   i_Judge        01 PERFECT, 10 GOOD, 11 MISS, 00 ignored
//   o_Score        current score, saturating
//   o_Combo        current combo, saturating
//   o_Max_Combo    highest combo this game
//   o_Sound_Cmd    00 silent, 01 perfect, 10 good, 11 miss tone
//   o_Playing      high while in PLAY
// master = judge/game side, slave = score_keeper.
interface score_keeper_if;
  logic        i_Start;
  logic        i_Stop;
  logic        i_Judge_Valid;
  logic [1:0]  i_Judge;
  logic [15:0] o_Score;
  logic [7:0]  o_Combo;
  logic [7:0]  o_Max_Combo;
  logic [1:0]  o_Sound_Cmd;
  logic        o_Playing;

  modport master (
    output i_Start, i_Stop, i_Judge_Valid, i_Judge,
    input  o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_Playing
  );

  modport slave (
    input  i_Start, i_Stop, i_Judge_Valid, i_Judge,
    output o_Score, o_Combo, o_Max_Combo, o_Sound_Cmd, o_Playing
  );
endinterface

// File: rtl/score_keeper.sv
// Score keeper: accumulates a saturating score with a combo-tier bonus,
// tracks current/maximum combo and issues a held sound command per judgment.
// Ports:
//   i_Clk    system clock
//   i_Rst_n  synchronous active-low reset
//   bus      score_keeper_if.slave (start/stop/judgment in, score/combo/sound out)
// All outputs are registered; a judgment sampled at edge N shows after edge N.
module score_keeper #(
  parameter int PERFECT_PTS = 10,
  parameter int GOOD_PTS    = 5,
  parameter int SCORE_MAX   = 9999,
  parameter int COMBO_MAX   = 99,
  parameter int BONUS_STEP  = 10,
  parameter int TIER_MAX    = 4,
  parameter int SND_HOLD    = 2500000
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  score_keeper_if.slave bus
);

  localparam int TW = $clog2(TIER_MAX + 1) < 1 ? 1 : $clog2(TIER_MAX + 1);
  localparam int SW = $clog2(BONUS_STEP + 1) < 1 ? 1 : $clog2(BONUS_STEP + 1);
  localparam int HW = $clog2(SND_HOLD + 1) < 1 ? 1 : $clog2(SND_HOLD + 1);

  localparam logic [TW-1:0] TIER_TOP    = TW'(TIER_MAX);
  localparam logic [SW-1:0] STREAK_LAST = SW'(BONUS_STEP - 1);
  localparam logic [HW-1:0] HOLD        = HW'(SND_HOLD);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
  localparam logic [16:0]   SCORE_TOP   = 17'(SCORE_MAX);
  localparam logic [7:0]    COMBO_TOP   = 8'(COMBO_MAX);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   score, score_nxt;
  logic [7:0]    combo, combo_nxt;
  logic [7:0]    max_combo, max_combo_nxt;
  logic [TW-1:0] tier, tier_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic [HW-1:0] timer, timer_nxt;
  logic [1:0]    snd, snd_nxt;

  logic          take;
  logic          hit;
  logic          miss;
  logic [16:0]   sum;

  // State and datapath registers
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
      tier      <= '0;
      streak    <= '0;
      timer     <= '0;
      snd       <= '0;
    end else begin
      state     <= state_nxt;
      score     <= score_nxt;
      combo     <= combo_nxt;
      max_combo <= max_combo_nxt;
      tier      <= tier_nxt;
      streak    <= streak_nxt;
      timer     <= timer_nxt;
      snd       <= snd_nxt;
    end
  end

  // Next state: start always wins, stop only matters in PLAY
  always_comb begin
    state_nxt = state;
    if (bus.i_Start)
      state_nxt = PLAY;
    else if (state == PLAY && bus.i_Stop)
      state_nxt = DONE;
  end

  // Judgment qualification; a judgment coinciding with start is dropped
  always_comb begin
    take = (state == PLAY) && bus.i_Judge_Valid && !bus.i_Start;
    hit  = take && (bus.i_Judge == 2'b01 || bus.i_Judge == 2'b10);
    miss = take && (bus.i_Judge == 2'b11);
  end

  // Next datapath values
  always_comb begin
    score_nxt     = score;
    combo_nxt     = combo;
    max_combo_nxt = max_combo;
    tier_nxt      = tier;
    streak_nxt    = streak;
    timer_nxt     = timer;
    snd_nxt       = snd;
    sum           = {1'b0, score} + 17'(tier) +
                    ((bus.i_Judge == 2'b01) ? 17'(PERFECT_PTS) : 17'(GOOD_PTS));

    if (bus.i_Start) begin
      score_nxt     = '0;
      combo_nxt     = '0;
      max_combo_nxt = '0;
      tier_nxt      = '0;
      streak_nxt    = '0;
      timer_nxt     = '0;
      snd_nxt       = '0;
    end else begin
      // Hold timer runs in every state so a tone issued with stop finishes
      if (timer != '0) begin
        timer_nxt = timer - 1'b1;
        if (timer == HOLD_ONE)
          snd_nxt = '0;
      end

      if (hit) begin
        score_nxt = (sum > SCORE_TOP) ? SCORE_TOP[15:0] : sum[15:0];
        combo_nxt = (combo < COMBO_TOP) ? combo + 8'd1 : COMBO_TOP;
        if (combo_nxt > max_combo)
          max_combo_nxt = combo_nxt;
        if (streak == STREAK_LAST) begin
          streak_nxt = '0;
          if (tier < TIER_TOP)
            tier_nxt = tier + 1'b1;
        end else begin
          streak_nxt = streak + 1'b1;
        end
        snd_nxt   = bus.i_Judge;
        timer_nxt = HOLD;
      end else if (miss) begin
        combo_nxt  = '0;
        streak_nxt = '0;
        tier_nxt   = '0;
        snd_nxt    = 2'b11;
        timer_nxt  = HOLD;
      end

      // Entering DONE silences the output unless a judgment came with stop
      if (state == PLAY && bus.i_Stop && !hit && !miss) begin
        snd_nxt   = '0;
        timer_nxt = '0;
      end
    end
  end

  assign bus.o_Score     = score;
  assign bus.o_Combo     = combo;
  assign bus.o_Max_Combo = max_combo;
  assign bus.o_Sound_Cmd = snd;
  assign bus.o_Playing   = (state == PLAY);

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Game-side producer for the score/combo/sound interface that drives the display and sound front end. It accepts per-note judgments from the judge logic and accumulates a saturating score with a combo-tier bonus. It tracks current and maximum combo and issues a held sound command per judgment. Its outputs connect directly to the display block's score, combo and sound-command inputs.

Parameters:
PERFECT_PTS, 10, base points for a PERFECT hit
GOOD_PTS, 5, base points for a GOOD hit
SCORE_MAX, 9999, score saturation ceiling (fits 4 display digits)
COMBO_MAX, 99, combo saturation ceiling (fits 2 display digits)
BONUS_STEP, 10, consecutive hits per bonus tier increment
TIER_MAX, 4, maximum bonus tier
SND_HOLD, 2500000, cycles a sound command is held (minimum 1)

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  synchronous active-low reset
i_Start  in  1  1-cycle pulse: clear all counters and enter PLAY
i_Stop  in  1  1-cycle pulse: end of song, enter DONE
i_Judge_Valid  in  1  judgment strobe, 1 cycle per note
i_Judge  in  2  01 PERFECT, 10 GOOD, 11 MISS, 00 ignored
o_Score  out  16  current score, 0..SCORE_MAX
o_Combo  out  8  current combo, 0..COMBO_MAX
o_Max_Combo  out  8  highest combo this game
o_Sound_Cmd  out  2  00 silent, 01 perfect tone, 10 good tone, 11 miss tone
o_Playing  out  1  high in PLAY

Behaviour:
- Reset (i_Rst_n=0 on a clock edge): state IDLE. All outputs are 0. Internal tier, streak counter and sound timer are 0. Reset asserted mid-game discards everything.
- All outputs are registered. A judgment sampled at edge N is visible after edge N (1-cycle latency).
- States:
  - IDLE: judgments and i_Stop are ignored. i_Start goes to PLAY.
  - PLAY: judgments are processed. i_Stop goes to DONE. i_Start restarts PLAY with everything cleared.
  - DONE: score, combo and max combo are frozen. Judgments and i_Stop are ignored. i_Start goes to PLAY with everything cleared.
- i_Start action: o_Score, o_Combo, o_Max_Combo, tier, streak and sound timer are cleared to 0. o_Sound_Cmd is set to 00.
- Simultaneous events:
  - i_Start wins over i_Stop and over a judgment in the same cycle; that judgment is dropped.
  - i_Stop together with a valid judgment in PLAY: the judgment is applied, then the state becomes DONE.
- Hit (PERFECT/GOOD, valid, PLAY):
  - pts = base + tier, using the tier value before this hit.
  - o_Score = min(o_Score + pts, SCORE_MAX). Compute the sum at 17 bits; no wrap.
  - o_Combo = min(o_Combo + 1, COMBO_MAX).
  - o_Max_Combo = max(o_Max_Combo, new o_Combo), updated in the same cycle.
  - streak increments. When streak reaches BONUS_STEP it resets to 0 and tier = min(tier + 1, TIER_MAX).
  - Streak keeps counting after combo saturates.
- MISS (valid, PLAY): score is unchanged. o_Combo, streak and tier are cleared to 0. o_Max_Combo is kept.
- i_Judge = 00 with valid: no effect on any state, including sound.
- Sound:
  - Each processed judgment loads o_Sound_Cmd with its code and loads the timer with SND_HOLD.
  - The timer decrements each cycle. When it reaches 0, o_Sound_Cmd becomes 00.
  - A new judgment retriggers the command and restarts the timer.
  - Entering DONE forces o_Sound_Cmd to 00 in the same cycle, unless a judgment arrives together with i_Stop. In that case its tone plays for the full hold time, then goes to 00.
- o_Playing = 1 exactly when the state is PLAY.

Test Plan:
1. Reset, then i_Start, then 10 PERFECTs -> score 100, combo 10, tier 1. 11th PERFECT -> score 111, combo 11.
2. With SND_HOLD=4: GOOD at cycle N -> o_Sound_Cmd=10 for 4 cycles, then 00. A PERFECT at N+2 -> 01 held 4 more cycles.
3. 5 PERFECTs, then MISS, then GOOD -> combo 5, 0, 1; max combo 5; score 55. The GOOD after MISS is scored at tier 0.
4. Saturation: 120 PERFECTs -> combo stuck at 99, score stuck at 9999 (force near-max via long run), tier capped at 4.
5. In a single cycle, i_Stop with PERFECT -> the hit is counted and state becomes DONE. A later PERFECT is ignored. i_Start with a MISS in one cycle -> all outputs 0, state PLAY.
6. Reset asserted mid-game with score 300 -> all outputs 0 next edge, state IDLE. Judgments are ignored until i_Start.
